// File: rtl/io_port_bridge.sv
// ---------------------------------------------------------------------------
// io_port_bridge
//
// Bridges a simple processor core's memory-mapped I/O port to two host
// valid/ready streams through a pair of small FIFOs.
//
//   Input path  (host -> core): host_in_* stream pushes, core_rd pops,
//                               head presented on read_in.
//   Output path (core -> host): core_wr pushes write_out, host_out_* stream
//                               pops.
//
// Ports
//   clock           single clock, rising edge
//   rst             asynchronous, active-high reset
//   read_in         input FIFO head, or EMPTY_WORD when empty
//   core_rd         core consumes read_in this cycle
//   write_out       word written by the core
//   core_wr         write_out valid this cycle
//   host_in_data    host -> core word
//   host_in_valid   host -> core word valid
//   host_in_ready   input FIFO can accept a word
//   host_out_data   output FIFO head
//   host_out_valid  output FIFO non-empty
//   host_out_ready  host accepts host_out_data this cycle
//   in_count        input FIFO occupancy (0..DEPTH)
//   out_count       output FIFO occupancy (0..DEPTH)
//   overflow        sticky: core_wr dropped because output FIFO was full
//   underflow       sticky: core_rd issued while input FIFO was empty
//   err_clr         synchronous clear of both sticky flags
// ---------------------------------------------------------------------------
module io_port_bridge #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [15:0] EMPTY_WORD = 16'h0000
) (
    input  logic                     clock,
    input  logic                     rst,
    output logic [15:0]              read_in,
    input  logic                     core_rd,
    input  logic [15:0]              write_out,
    input  logic                     core_wr,
    input  logic [15:0]              host_in_data,
    input  logic                     host_in_valid,
    output logic                     host_in_ready,
    output logic [15:0]              host_out_data,
    output logic                     host_out_valid,
    input  logic                     host_out_ready,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Storage is not reset; it is only observed through a non-zero count.
    logic [15:0]   in_mem_q  [DEPTH];
    logic [15:0]   out_mem_q [DEPTH];

    logic [PW-1:0] in_wr_ptr_q,  in_wr_ptr_d;
    logic [PW-1:0] in_rd_ptr_q,  in_rd_ptr_d;
    logic [CW-1:0] in_count_q,   in_count_d;
    logic [PW-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [PW-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [CW-1:0] out_count_q,  out_count_d;
    logic          overflow_q,   overflow_d;
    logic          underflow_q,  underflow_d;

    logic in_push, in_pop, in_err;
    logic out_push, out_pop, out_err;

    always_comb begin
        // Input FIFO: ready depends only on registered occupancy.
        in_push = host_in_valid && (in_count_q != FULL);
        in_pop  = core_rd && (in_count_q != '0);
        in_err  = core_rd && (in_count_q == '0);

        // Output FIFO: a same-cycle host pop frees the slot a full FIFO needs.
        out_pop  = host_out_ready && (out_count_q != '0);
        out_push = core_wr && ((out_count_q != FULL) || out_pop);
        out_err  = core_wr && (out_count_q == FULL) && !out_pop;

        in_wr_ptr_d  = in_push  ? in_wr_ptr_q  + 1'b1 : in_wr_ptr_q;
        in_rd_ptr_d  = in_pop   ? in_rd_ptr_q  + 1'b1 : in_rd_ptr_q;
        out_wr_ptr_d = out_push ? out_wr_ptr_q + 1'b1 : out_wr_ptr_q;
        out_rd_ptr_d = out_pop  ? out_rd_ptr_q + 1'b1 : out_rd_ptr_q;

        in_count_d = in_count_q;
        case ({in_push, in_pop})
            2'b10:   in_count_d = in_count_q + ONE;
            2'b01:   in_count_d = in_count_q - ONE;
            default: in_count_d = in_count_q;
        endcase

        out_count_d = out_count_q;
        case ({out_push, out_pop})
            2'b10:   out_count_d = out_count_q + ONE;
            2'b01:   out_count_d = out_count_q - ONE;
            default: out_count_d = out_count_q;
        endcase

        // A clear loses to an error event in the same cycle.
        overflow_d  = err_clr ? out_err : (overflow_q  || out_err);
        underflow_d = err_clr ? in_err  : (underflow_q || in_err);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_count_q   <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_count_q  <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_count_q   <= in_count_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_count_q  <= out_count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (in_push) begin
            in_mem_q[in_wr_ptr_q] <= host_in_data;
        end
        if (out_push) begin
            out_mem_q[out_wr_ptr_q] <= write_out;
        end
    end

    assign read_in        = (in_count_q != '0) ? in_mem_q[in_rd_ptr_q] : EMPTY_WORD;
    assign host_in_ready  = (in_count_q != FULL);
    assign host_out_valid = (out_count_q != '0);
    assign host_out_data  = (out_count_q != '0) ? out_mem_q[out_rd_ptr_q] : '0;
    assign in_count       = in_count_q;
    assign out_count      = out_count_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per FIFO; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter EMPTY_WORD, default 16'h0000, meaning the value driven on read_in when the input FIFO is empty.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port read_in, output, 16 bits: word presented to the core's input port.
REQ-006 SHALL have port core_rd, input, 1 bit: the core consumes read_in this cycle.
REQ-007 SHALL have port write_out, input, 16 bits: word from the core's output port.
REQ-008 SHALL have port core_wr, input, 1 bit: write_out is valid this cycle (memwrite-qualified).
REQ-009 SHALL have ports host_in_data (input, 16 bits), host_in_valid (input, 1 bit) and host_in_ready (output, 1 bit): host-to-core stream.
REQ-010 SHALL have ports host_out_data (output, 16 bits), host_out_valid (output, 1 bit) and host_out_ready (input, 1 bit): core-to-host stream.
REQ-011 SHALL have ports in_count and out_count, outputs, $clog2(DEPTH)+1 bits each: current FIFO occupancies.
REQ-012 SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.
REQ-013 SHALL have port err_clr, input, 1 bit: synchronous clear of overflow and underflow.

Function
REQ-014 The input FIFO SHALL accept a push exactly when host_in_valid && host_in_ready; host_in_ready = (in_count != DEPTH), derived from registered state only.
REQ-015 read_in SHALL equal the input FIFO head when in_count > 0, else EMPTY_WORD; it is combinational from registered storage, with no host-to-core bypass.
REQ-016 Latency from an accepted host push to read_in showing that word (FIFO previously empty) SHALL be 1 cycle.
REQ-017 core_rd with in_count > 0 SHALL pop the head; core_rd with in_count == 0 SHALL leave the FIFO unchanged and set underflow.
REQ-018 A simultaneous push and pop on the input FIFO with 0 < in_count < DEPTH SHALL leave in_count unchanged and preserve ordering.
REQ-019 A push and a core_rd in the same cycle with in_count == 0 SHALL store the pushed word (in_count becomes 1) and set underflow.
REQ-020 The output FIFO SHALL push write_out when core_wr is high and either out_count < DEPTH or a host pop occurs in the same cycle.
REQ-021 core_wr with out_count == DEPTH and no host pop in the same cycle SHALL drop the word, set overflow, and leave the FIFO unchanged.
REQ-022 host_out_valid SHALL equal (out_count > 0) and host_out_data SHALL equal the FIFO head; a pop occurs on host_out_valid && host_out_ready.
REQ-023 host_out_data SHALL remain stable while host_out_valid is high and host_out_ready is low.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH; counts SHALL range 0..DEPTH inclusive.
REQ-025 overflow and underflow SHALL hold once set until err_clr or rst.
REQ-026 err_clr SHALL clear both flags; a same-cycle error event SHALL take priority, leaving the corresponding flag set.
REQ-027 Both FIFOs SHALL be strictly first-in first-out with no reordering or duplication.

Reset
REQ-028 While rst is high, the block SHALL immediately (asynchronously) clear all pointers and counts to 0 and clear overflow and underflow to 0.
REQ-029 Outputs during and after reset SHALL be: read_in = EMPTY_WORD, host_in_ready = 1, host_out_valid = 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered words; no push or pop SHALL be recorded on the cycle rst deasserts if rst is still high at that edge.
REQ-031 FIFO storage contents need not be reset; they SHALL never be visible while the corresponding count is 0.

Verification
REQ-032 Host pushes 16'h1234 then 16'hABCD, core_rd idle: read_in = 16'h1234 one cycle after the first push; after one core_rd, read_in = 16'hABCD and in_count = 1.
REQ-033 DEPTH = 4, host pushes 5 words with host_in_valid held high: host_in_ready = 0 after 4 accepts, the 5th word is held, in_count = 4, overflow = 0.
REQ-034 core_rd pulsed on an empty FIFO: underflow = 1, read_in = 16'h0000, in_count = 0; err_clr then clears underflow to 0.
REQ-035 host_out_ready = 0 and core_wr writes 16'h0001..16'h0005 (DEPTH = 4): out_count = 4, overflow = 1, and the host subsequently receives 1, 2, 3, 4 in order.
REQ-036 Output FIFO full, core_wr = 1 with write_out = 16'h00FF and host pop in the same cycle: no overflow, out_count stays 4, and 16'h00FF is last in order.
REQ-037 rst pulsed asynchronously mid-cycle with both FIFOs holding 2 words: counts = 0, host_out_valid = 0, read_in = EMPTY_WORD before the next clock edge.
